ddr3_rd_arbiter: RTL

- Round-robin scheduler sharing the single DDR3 read-command port between up to four read clients (HDMI out, UDP, VGA-A, VGA-B).
- Each client holds a req/addr pair and receives a one-cycle ref pulse when its command is accepted. This is the same req/addr/ref handshake HDMI_RD_DDR3 already uses.
- Read data returning with rid is decoded into per-client valid strobes.
- Tracks outstanding bursts so the DDR3 controller is never asked for more than it can buffer.

---
 rtl/ddr3_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/ddr3_rd_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ddr3_pkg.sv
// rtl/ddr3_pkg.sv - shared encodings for the DDR3 read-command arbiter
// Purpose: read-id assignments of the four clients, arbiter FSM state
//          encoding and the default address width.
// Ports:   none (package).
package ddr3_pkg;

  localparam int ADDR_W_DEF = 16;

  // Client index doubles as the DDR3 read id.
  localparam logic [3:0] RID_HDMI = 4'd0;
  localparam logic [3:0] RID_UDP  = 4'd1;
  localparam logic [3:0] RID_VGAA = 4'd2;
  localparam logic [3:0] RID_VGAB = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
// Purpose: finds the first set request bit searching upward from ptr_i,
//          wrapping modulo NUM_REQ.
// Ports:   req_i  - request vector
//          ptr_i  - index with highest priority this round
//          idx_o  - index of the selected request (0 when none)
//          any_o  - at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [1:0]         idx_o,
  output logic               any_o
);

  always_comb begin
    int c;
    c     = 0;
    idx_o = 2'd0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[c]) begin
        any_o = 1'b1;
        idx_o = 2'(c);
      end
    end
  end

endmodule

// File: rtl/ddr3_rd_arbiter.sv
// rtl/ddr3_rd_arbiter.sv - round-robin arbiter for the DDR3 read-command port
// Purpose: shares one DDR3 read-command port between up to four clients with
//          a req/addr/ref handshake, routes returning read data by rid and
//          limits the number of bursts in flight.
// Ports:   clk_100M   - DDR3 user clock
//          rst        - asynchronous active-high reset
//          req/addr   - per-client request level and address
//          ref_o      - one-cycle accept pulse per client
//          cmd_*      - read command towards the controller
//          rdata_vld/rid/rlast - read data return qualifiers
//          client_vld - rdata_vld decoded by rid
//          busy       - FSM active or bursts outstanding
//          error_id   - sticky bad-rid / spurious-rlast flag
module ddr3_rd_arbiter
  import ddr3_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_OUTST = 4
) (
  input  logic                      clk_100M,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        ref_o,
  output logic                      cmd_valid,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [3:0]                cmd_id,
  input  logic                      cmd_ready,
  input  logic                      rdata_vld,
  input  logic [3:0]                rid,
  input  logic                      rlast,
  output logic [NUM_REQ-1:0]        client_vld,
  output logic                      busy,
  output logic                      error_id
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  arb_state_e         state_q, state_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
  logic [3:0]         cmd_id_q, cmd_id_d;
  logic [NUM_REQ-1:0] ref_q, ref_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]      outst_q, outst_d;
  logic               err_q, err_d;

  logic               rst_meta_q, rst_sync_q;
  logic [1:0]         pick_idx;
  logic               pick_any;
  logic               cmd_hs;
  logic               burst_done;
  logic               credit_ok;

  // Reset asserts at once but releases only after two clock edges so all
  // state leaves reset on the same cycle.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign credit_ok = (outst_q < OW'(MAX_OUTST));

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_id_d    = cmd_id_q;
    rr_ptr_d    = rr_ptr_q;
    ref_d       = '0;
    cmd_hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|req) && credit_ok) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A request that vanished between IDLE and GRANT simply retries.
        if (pick_any) begin
          cmd_valid_d = 1'b1;
          cmd_addr_d  = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          cmd_id_d    = {2'b00, pick_idx};
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_hs      = 1'b1;
          cmd_valid_d = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            ref_d[i] = (cmd_id_q == 4'(i));
          end
          // Served client drops to lowest priority.
          rr_ptr_d = (cmd_id_q[1:0] == 2'(NUM_REQ - 1)) ? 2'd0 : cmd_id_q[1:0] + 2'd1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // An rlast with nothing outstanding is flagged but never underflows.
  assign burst_done = rdata_vld && rlast && (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    if (cmd_hs && !burst_done) begin
      outst_d = outst_q + OW'(1);
    end else if (burst_done && !cmd_hs) begin
      outst_d = outst_q - OW'(1);
    end
    err_d = err_q
          | (rdata_vld && (rid >= 4'(NUM_REQ)))
          | (rdata_vld && rlast && (outst_q == '0));
  end

  always_ff @(posedge clk_100M or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_id_q    <= 4'd0;
      ref_q       <= '0;
      rr_ptr_q    <= 2'd0;
      outst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_id_q    <= cmd_id_d;
      ref_q       <= ref_d;
      rr_ptr_q    <= rr_ptr_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    client_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      client_vld[i] = rdata_vld && (rid == 4'(i));
    end
  end

  assign ref_o     = ref_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_id    = cmd_id_q;
  assign busy      = (state_q != ST_IDLE) || (outst_q != '0);
  assign error_id  = err_q;

endmodule
